// File: rtl/serial_add_arbiter_pkg.sv
// rtl/serial_add_arbiter_pkg.sv - shared types and helpers for the serial add arbiter
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  // Bit-counter width: enough to count 0..w-1, never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Requester-ID width for n requesters.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin pick: first asserted bit searching upward from last+1,
  // wrapping modulo nreq. Visiting farthest-first lets the nearest win.
  function automatic logic [1:0] rr_pick(input logic [3:0] valid,
                                         input logic [1:0] last,
                                         input int nreq);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = last;
    for (int k = nreq; k >= 1; k--) begin
      idx = 2'((int'(last) + k) % nreq);
      if (valid[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/serial_add_arbiter_if.sv
// rtl/serial_add_arbiter_if.sv - request/response bundle between clients and the serial adder
interface serial_add_arbiter_if import serial_add_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2
);
  localparam int IW = id_w(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IW-1:0]         rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  busy;

  // Client side: requesters plus the response consumer.
  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  // Engine side.
  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

endinterface

// File: rtl/serial_add_arbiter_fulladder.sv
// rtl/serial_add_arbiter_fulladder.sv - gate-level one-bit full adder cell
module fulladder (
  input  wire a,
  input  wire b,
  input  wire c_in,
  output wire s,
  output wire c_out
);
  wire p;
  wire g;
  wire t;

  xor u_x0 (p, a, b);
  xor u_x1 (s, p, c_in);
  and u_a0 (g, a, b);
  and u_a1 (t, p, c_in);
  or  u_o0 (c_out, g, t);

endmodule

// File: rtl/serial_add_arbiter.sv
// rtl/serial_add_arbiter.sv - round-robin shared bit-serial adder engine
module serial_add_arbiter import serial_add_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2
) (
  input logic          clk,
  input logic          rst_n,
  serial_add_arbiter_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  localparam int IW = id_w(NREQ);

  localparam logic [1:0] IDLE  = S_IDLE;
  localparam logic [1:0] SHIFT = S_SHIFT;
  localparam logic [1:0] RESP  = S_RESP;

  logic [1:0]       state;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    rsp_id_q;
  logic [IW-1:0]    sel;
  logic [1:0]       pick_idx;
  logic             any_valid;
  logic             accept;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             cin_sel;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_c;
  logic             rsp_valid_q;
  logic             busy_q;
  logic [NREQ-1:0]  ready;

  // The single shared adder cell; all arithmetic goes through it.
  fulladder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_c)
  );

  // Pick a winner and steer its operands; accept only from IDLE and
  // never while reset is held, so req_ready reads 0 during reset.
  always_comb begin
    pick_idx  = rr_pick(4'(bus.req_valid), 2'(last_grant), NREQ);
    sel       = IW'(pick_idx);
    any_valid = |bus.req_valid;
    accept    = rst_n && (state == IDLE) && any_valid;
    a_sel     = bus.req_a[sel*WIDTH +: WIDTH];
    b_sel     = bus.req_b[sel*WIDTH +: WIDTH];
    cin_sel   = bus.req_cin[sel];
    last_bit  = (cnt == CW'(WIDTH - 1));
  end

  // One-hot accept strobe for the granted requester.
  always_comb begin
    ready = '0;
    if (accept) ready[sel] = 1'b1;
  end

  // Engine FSM: capture, shift one bit per clock, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= IW'(NREQ - 1);
      rsp_id_q    <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh       <= a_sel;
            b_sh       <= b_sel;
            carry      <= cin_sel;
            cnt        <= '0;
            last_grant <= sel;
            busy_q     <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= fa_c;
          if (last_bit) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= last_grant;
            state       <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = sum_sh;
  assign bus.rsp_cout  = carry;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb/tb_serial_add_arbiter.sv - self-checking bench for serial_add_arbiter
module tb_serial_add_arbiter;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  serial_add_arbiter_if #(.WIDTH(8), .NREQ(2)) bus ();

  serial_add_arbiter #(.WIDTH(8), .NREQ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         req;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Round-robin rule: first requester asking, searching from last+1.
  function automatic int rr_ref(input logic [1:0] v, input int last);
    for (int k = 1; k <= 2; k++) begin
      int i;
      i = (last + k) % 2;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b, input logic c);
    bus.req_a[r*8 +: 8] = a;
    bus.req_b[r*8 +: 8] = b;
    bus.req_cin[r]      = c;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    #1;
    while (!bus.rsp_valid && lat < 30) begin
      @(negedge clk); #1; lat++;
    end
    chk("rsp_timeout", 32'(lat < 30), 1);
  endtask

  // One isolated operation on requester req with rsp_ready high.
  task automatic run_single(input int req, input logic [7:0] a, input logic [7:0] b, input logic cin,
                            output logic [7:0] s, output logic co, output logic [31:0] id, output int lat);
    int n;
    @(negedge clk);
    set_req(req, a, b, cin);
    bus.req_valid[req] = 1'b1;
    bus.rsp_ready      = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready[req] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_timeout", 32'(n < 20), 1);
    @(negedge clk);
    bus.req_valid = '0;
    wait_rsp(lat);
    s  = bus.rsp_sum;
    co = bus.rsp_cout;
    id = 32'(bus.rsp_id);
    @(negedge clk); #1;
    chk("idle_after_rsp", 32'(bus.busy), 0);
  endtask

  int         g_id[8];
  int         g_cyc[8];
  int         g_cnt;
  logic [7:0] s_got;
  logic       c_got;
  logic [31:0] id_got;
  int         lat;
  int         n;
  int         seen;

  logic [7:0] pa[2];
  logic [7:0] pb[2];
  logic       pc[2];
  bit         pend[2];
  int         model_last;
  bit         mbusy;
  int         acc_it;
  logic [8:0] exp_res;
  int         exp_id;
  int         done;
  int         g;
  logic [1:0] exp_ready;
  logic       exp_v;

  initial begin
    vecs[0] = '{0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{1, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[4] = '{1, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[5] = '{0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

    // Reset state, with both requesters asking during reset.
    rst_n = 1'b0;
    clear_inputs();
    bus.req_valid = 2'b11;
    @(negedge clk); #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id",    32'(bus.rsp_id), 0);
    chk("rst_rsp_sum",   32'(bus.rsp_sum), 0);
    chk("rst_rsp_cout",  32'(bus.rsp_cout), 0);
    chk("rst_busy",      32'(bus.busy), 0);

    // Table-driven single operations.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_single(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].cin, s_got, c_got, id_got, lat);
      chk("vec_sum",  32'(s_got), 32'(vecs[i].sum));
      chk("vec_cout", 32'(c_got), 32'(vecs[i].cout));
      chk("vec_id",   id_got, 32'(vecs[i].req));
      chk("vec_latency", 32'(lat), 9);
    end

    // Fairness: both requesters asking continuously from reset.
    do_reset();
    @(negedge clk);
    set_req(0, 8'h10, 8'h01, 1'b0);
    set_req(1, 8'h20, 8'h02, 1'b0);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    #1;
    g_cnt = 0;
    for (int it = 0; it < 80 && g_cnt < 4; it++) begin
      if (bus.req_ready != 2'b00) begin
        g_id[g_cnt]  = bus.req_ready[1] ? 1 : 0;
        g_cyc[g_cnt] = it;
        g_cnt++;
      end
      @(negedge clk); #1;
    end
    chk("fair_count", 32'(g_cnt), 4);
    for (int k = 0; k < 4; k++) chk("fair_order", 32'(g_id[k]), 32'(k % 2));
    for (int k = 1; k < 4; k++) chk("fair_interval", 32'(g_cyc[k] - g_cyc[k-1]), 10);

    // Only requester 1 asking: back-to-back grants every WIDTH+2 cycles.
    do_reset();
    @(negedge clk);
    set_req(1, 8'h33, 8'h44, 1'b0);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 1'b1;
    #1;
    g_cnt = 0;
    for (int it = 0; it < 80 && g_cnt < 3; it++) begin
      if (bus.req_ready != 2'b00) begin
        g_id[g_cnt]  = bus.req_ready[1] ? 1 : 0;
        g_cyc[g_cnt] = it;
        g_cnt++;
      end
      @(negedge clk); #1;
    end
    chk("solo_count", 32'(g_cnt), 3);
    for (int k = 0; k < 3; k++) chk("solo_id", 32'(g_id[k]), 1);
    for (int k = 1; k < 3; k++) chk("solo_interval", 32'(g_cyc[k] - g_cyc[k-1]), 10);

    // Backpressure: response held for 5 cycles, handshake on the 6th.
    do_reset();
    @(negedge clk);
    set_req(0, 8'h5A, 8'h3C, 1'b0);
    set_req(1, 8'h01, 8'h02, 1'b0);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp_first_grant", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 2'b10;
    wait_rsp(lat);
    chk("bp_latency", 32'(lat), 9);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_sum",   32'(bus.rsp_sum), 32'h96);
      chk("bp_cout",  32'(bus.rsp_cout), 0);
      chk("bp_id",    32'(bus.rsp_id), 0);
      chk("bp_ready", 32'(bus.req_ready), 0);
      chk("bp_busy",  32'(bus.busy), 1);
      @(negedge clk);
      if (k == 4) bus.rsp_ready = 1'b1;
      #1;
    end
    chk("bp_hs_valid", 32'(bus.rsp_valid), 1);
    chk("bp_hs_sum",   32'(bus.rsp_sum), 32'h96);
    chk("bp_hs_ready", 32'(bus.req_ready), 0);
    @(negedge clk); #1;
    chk("bp_idle_valid", 32'(bus.rsp_valid), 0);
    chk("bp_idle_busy",  32'(bus.busy), 0);
    chk("bp_next_grant", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_rsp(lat);
    chk("bp_req1_sum", 32'(bus.rsp_sum), 32'h03);
    chk("bp_req1_id",  32'(bus.rsp_id), 1);

    // Reset during SHIFT bit 4: no response, then requester 0 wins again.
    do_reset();
    @(negedge clk);
    set_req(0, 8'h11, 8'h22, 1'b0);
    set_req(1, 8'h33, 8'h44, 1'b0);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    #1;
    chk("mr_first_grant", 32'(bus.req_ready), 32'h1);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_req_ready", 32'(bus.req_ready), 0);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mr_rsp_id",    32'(bus.rsp_id), 0);
    chk("mr_rsp_sum",   32'(bus.rsp_sum), 0);
    chk("mr_rsp_cout",  32'(bus.rsp_cout), 0);
    chk("mr_busy",      32'(bus.busy), 0);
    set_req(0, 8'h70, 8'h0F, 1'b1);
    repeat (2) begin
      @(negedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_regrant", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 2'b10;
    #1;
    if (bus.rsp_valid) seen++;
    lat = 1;
    while (!bus.rsp_valid && lat < 30) begin
      @(negedge clk); #1; lat++;
    end
    chk("mr_no_stale_rsp", 32'(seen), 0);
    chk("mr_latency", 32'(lat), 9);
    chk("mr_sum",  32'(bus.rsp_sum), 32'h80);
    chk("mr_cout", 32'(bus.rsp_cout), 0);
    chk("mr_id",   32'(bus.rsp_id), 0);

    // Random traffic against the arithmetic and round-robin model.
    do_reset();
    pend[0] = 0; pend[1] = 0;
    model_last = 1;
    mbusy = 0;
    acc_it = 0;
    exp_res = '0;
    exp_id = 0;
    done = 0;
    for (int it = 0; it < 40000 && done < 1000; it++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          bus.req_valid[i] = 1'b0;
          if ($urandom_range(0, 2) != 0) begin
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
            pc[i] = 1'($urandom);
            set_req(i, pa[i], pb[i], pc[i]);
            bus.req_valid[i] = 1'b1;
            pend[i] = 1;
          end
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = 2'b00;
      g = -1;
      if (!mbusy && (pend[0] || pend[1])) begin
        g = rr_ref({pend[1], pend[0]}, model_last);
        exp_ready[g] = 1'b1;
      end
      exp_v = mbusy && (it >= acc_it + 9);
      chk("rnd_ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
      chk("rnd_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
      chk("rnd_busy", 32'(bus.busy), 32'(mbusy));
      if (exp_v) begin
        chk("rnd_sum",  32'(bus.rsp_sum), 32'(exp_res[7:0]));
        chk("rnd_cout", 32'(bus.rsp_cout), 32'(exp_res[8]));
        chk("rnd_id",   32'(bus.rsp_id), 32'(exp_id));
        if (bus.rsp_ready) begin
          mbusy = 0;
          done++;
        end
      end
      if (g >= 0) begin
        mbusy = 1;
        acc_it = it;
        model_last = g;
        exp_res = 9'(pa[g]) + 9'(pb[g]) + 9'(pc[g]);
        exp_id = g;
        pend[g] = 0;
      end
    end
    chk("rnd_ops_done", 32'(done), 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
